// File: rtl/cic_decimator_pkg.sv
// Shared width constants and the CIC width-rule helpers used by the decimator and its comb stages.
package cic_decimator_pkg;

  localparam int N_DEF = 16;
  localparam int K_DEF = 3;
  localparam int R_DEF = 8;
  localparam int K_MIN = 1;
  localparam int K_MAX = 6;
  localparam int R_MIN = 2;
  localparam int R_MAX = 256;

  function automatic int clog2(input int value);
    int bits;
    int span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span * 2;
      bits++;
    end
    return bits;
  endfunction

  // Bit growth of a CIC is order * log2(ratio); anything narrower loses the exact output.
  function automatic int min_width(input int in_w, input int order, input int ratio);
    return in_w + order * clog2(ratio);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section: subtracts the previous decimated value, updated only on output-rate strobes.
module cic_comb_stage
  import cic_decimator_pkg::*;
#(
  parameter int m = min_width(N_DEF, K_DEF, R_DEF)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en_i,
  input  logic signed [m-1:0] c_i,
  output logic signed [m-1:0] c_o
);

  logic signed [m-1:0] z_q;

  // Modulo-2^m wrap here is what makes the CIC output exact.
  assign c_o = c_i - z_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      z_q <= '0;
    end else if (en_i) begin
      z_q <= c_i;
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// Cascaded integrator-comb decimator: k integrators at input rate, decimate by r, k combs at output rate.
module cic_decimator
  import cic_decimator_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int k = K_DEF,
  parameter int r = R_DEF,
  parameter int m = min_width(n, k, r)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic signed [n-1:0] in,
  input  logic                in_valid,
  output logic signed [m-1:0] out,
  output logic                out_valid
);

  localparam int CW = clog2(r);
  localparam logic [CW-1:0] CNT_LAST = CW'(r - 1);

  if (k < K_MIN || k > K_MAX || r < R_MIN || r > R_MAX || m < min_width(n, k, r)) begin : g_bad_param
    $error("cic_decimator: illegal order/ratio or output width below n + k*clog2(r)");
  end

  logic signed [m-1:0] x_ext;
  logic signed [m-1:0] int_q [k];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [m-1:0] d_q;
  logic                dv_q;
  logic signed [m-1:0] out_q;
  logic                out_valid_q;

  assign x_ext = m'(in);

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: async clr clears every stage at once; the integrators are few, so all of them are reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int j = 0; j < k; j++) int_q[j] <= '0;
      cnt_q <= '0;
      d_q   <= '0;
      dv_q  <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      cnt_q <= cnt_d;
      if (in_valid) begin
        // NOTE: non-blocking updates make each stage add its predecessor's pre-edge value (pipelined chain).
        int_q[0] <= int_q[0] + x_ext;
        for (int j = 1; j < k; j++) int_q[j] <= int_q[j] + int_q[j-1];
        if (cnt_q == CNT_LAST) begin
          d_q  <= int_q[k-1];
          dv_q <= 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < k; j++) begin : g_comb
    logic signed [m-1:0] c_in;
    logic signed [m-1:0] c_out;
    if (j == 0) begin : g_first
      assign c_in = d_q;
    end else begin : g_next
      assign c_in = g_comb[j-1].c_out;
    end
    cic_comb_stage #(.m(m)) u_stage (
      .clk  (clk),
      .clr  (clr),
      .en_i (dv_q),
      .c_i  (c_in),
      .c_o  (c_out)
    );
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= dv_q;
      if (dv_q) out_q <= g_comb[k-1].c_out;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: default build (k=3, r=8) plus a k=1, r=4 build for the impulse case.
module tb_cic_decimator;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic signed [15:0] din = '0;
  logic               din_valid = 1'b0;
  logic signed [24:0] dout;
  logic               dout_valid;
  logic signed [15:0] imp_din = '0;
  logic               imp_valid = 1'b0;
  logic signed [17:0] imp_out;
  logic               imp_out_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic signed [24:0] outs[$];
  int                 out_cyc[$];
  logic signed [17:0] imp_outs[$];
  int                 imp_cyc[$];

  // Third-order response to a unit step, decimated by 8: differences of C(8j-1,3).
  logic signed [24:0] exp_dc [5] = '{25'sd35, 25'sd350, 25'sd511, 25'sd512, 25'sd512};

  cic_decimator u_dut (
    .clk       (clk),
    .clr       (clr),
    .in        (din),
    .in_valid  (din_valid),
    .out       (dout),
    .out_valid (dout_valid)
  );

  cic_decimator #(.n(16), .k(1), .r(4)) u_imp (
    .clk       (clk),
    .clr       (clr),
    .in        (imp_din),
    .in_valid  (imp_valid),
    .out       (imp_out),
    .out_valid (imp_out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic signed [63:0] get_out(input int i);
    return (i < outs.size()) ? 64'(outs[i]) : 'x;
  endfunction

  function automatic int get_cyc(input int i);
    return (i < out_cyc.size()) ? out_cyc[i] : -1;
  endfunction

  task automatic clear_capture();
    outs.delete();
    out_cyc.delete();
    imp_outs.delete();
    imp_cyc.delete();
    cyc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dout_valid === 1'b1) begin
      outs.push_back(dout);
      out_cyc.push_back(cyc);
    end
    if (imp_out_valid === 1'b1) begin
      imp_outs.push_back(imp_out);
      imp_cyc.push_back(cyc);
    end
  endtask

  task automatic drive(input logic signed [15:0] x, input logic v);
    @(negedge clk);
    din       = x;
    din_valid = v;
    imp_valid = 1'b0;
    tick();
  endtask

  task automatic drive_imp(input logic signed [15:0] x, input logic v);
    @(negedge clk);
    imp_din   = x;
    imp_valid = v;
    din_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr       = 1'b1;
    din_valid = 1'b0;
    imp_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    clear_capture();
  endtask

  initial begin
    // Reset state, including samples offered while clr is held.
    #1;
    check("rst_out", dout, 0);
    check("rst_out_valid", dout_valid, 0);
    check("rst_imp_out", imp_out, 0);
    @(negedge clk);
    din = 16'sd1;
    din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_out", dout, 0);
    check("rst_held_valid", dout_valid, 0);

    // DC step, unit input every cycle.
    do_reset();
    repeat (41) drive(16'sd1, 1'b1);
    check("dc_count", outs.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("dc_out%0d", i), get_out(i), exp_dc[i]);
    check("dc_first_latency", get_cyc(0), 9);
    for (int i = 0; i < 4; i++) check($sformatf("dc_spacing%0d", i), get_cyc(i + 1) - get_cyc(i), 8);
    check("pre_clr_valid", dout_valid, 1);
    check("pre_clr_out", dout, 512);

    // Mid-block clr clears outputs without waiting for an edge.
    @(negedge clk);
    clr = 1'b1;
    din_valid = 1'b0;
    #1;
    check("midclr_out", dout, 0);
    check("midclr_valid", dout_valid, 0);
    @(negedge clk);
    clr = 1'b0;
    clear_capture();
    repeat (33) drive(16'sd1, 1'b1);
    check("fresh_count", outs.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("fresh_out%0d", i), get_out(i), exp_dc[i]);

    // clr coincident with the sample that would complete a block.
    do_reset();
    repeat (7) drive(16'sd1, 1'b1);
    check("coin_pre_count", outs.size(), 0);
    @(negedge clk);
    clr = 1'b1;
    din = 16'sd1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    check("coin_valid", dout_valid, 0);
    @(negedge clk);
    clr = 1'b0;
    din_valid = 1'b0;
    clear_capture();
    repeat (8) drive(16'sd1, 1'b1);
    check("coin_early_count", outs.size(), 0);
    drive(16'sd0, 1'b0);
    check("coin_count", outs.size(), 1);
    check("coin_out", get_out(0), 35);
    check("coin_latency", get_cyc(0), 9);

    // Gapped input: one accepted sample every third cycle.
    do_reset();
    repeat (33) begin
      drive(16'sd1, 1'b1);
      drive(16'sd0, 1'b0);
      drive(16'sd0, 1'b0);
    end
    check("gap_count", outs.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("gap_out%0d", i), get_out(i), exp_dc[i]);
    check("gap_first", get_cyc(0), 23);
    for (int i = 0; i < 3; i++) check($sformatf("gap_spacing%0d", i), get_cyc(i + 1) - get_cyc(i), 24);

    // Impulse through the first-order, ratio-4 build.
    do_reset();
    drive_imp(16'sd1, 1'b1);
    repeat (12) drive_imp(16'sd0, 1'b1);
    check("imp_count", imp_outs.size(), 3);
    check("imp_out0", (imp_outs.size() > 0) ? 64'(imp_outs[0]) : 'x, 1);
    check("imp_out1", (imp_outs.size() > 1) ? 64'(imp_outs[1]) : 'x, 0);
    check("imp_out2", (imp_outs.size() > 2) ? 64'(imp_outs[2]) : 'x, 0);
    check("imp_latency", (imp_cyc.size() > 0) ? imp_cyc[0] : -1, 5);

    // Full-scale inputs: integrators wrap many times, output stays exact.
    do_reset();
    repeat (10000) drive(16'sd32767, 1'b1);
    check("fs_pos_count", outs.size(), 1249);
    check("fs_pos_out", dout, 16776704);
    repeat (80) drive(-16'sd32768, 1'b1);
    check("fs_neg_out", dout, -16777216);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
